// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared widths, blank line constant and scheduler state type
package lcd_pkg;

  localparam int LCD_LINE_W = 128;

  localparam logic [LCD_LINE_W-1:0] LCD_BLANK_LINE = {16{8'h20}};

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } sched_state_t;

endpackage

// File: rtl/lcd_rr_pick.sv
// rtl/lcd_rr_pick.sv - combinational one-hot winner pick (round-robin or fixed priority)
module lcd_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter bit RR_EN   = 1'b1
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         pick,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx,
  output logic                       any
);

  localparam int PW = $clog2(NUM_REQ);

  int            start;
  logic [PW-1:0] idx;
  logic          found;

  // Search upward from start+1 with wrap; fixed priority is the same search
  // anchored at NUM_REQ-1 so index 0 is always examined first.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = '0;
    start    = RR_EN ? int'(ptr) : NUM_REQ - 1;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((start + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/lcd_msg_scheduler.sv
// rtl/lcd_msg_scheduler.sv - shares the LCD between requesters with dwell time; LCD_SCHED_RR_EN selects round-robin
module lcd_msg_scheduler
  import lcd_pkg::*;
#(
  parameter int                    NUM_REQ       = 2,
  parameter int                    DWELL_CYCLES  = 50_000_000,
  parameter logic [LCD_LINE_W-1:0] DEFAULT_LINE1 = LCD_BLANK_LINE,
  parameter logic [LCD_LINE_W-1:0] DEFAULT_LINE2 = LCD_BLANK_LINE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*LCD_LINE_W-1:0]   req_line1,
  input  logic [NUM_REQ*LCD_LINE_W-1:0]   req_line2,
  output logic [NUM_REQ-1:0]              grant,
  output logic [LCD_LINE_W-1:0]           line1,
  output logic [LCD_LINE_W-1:0]           line2,
  output logic                            upd,
  output logic [$clog2(NUM_REQ)-1:0]      owner,
  output logic                            owner_valid,
  output logic                            busy
);

  localparam int OW    = $clog2(NUM_REQ);
  localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYCLES - 1);

  sched_state_t          state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [OW-1:0]         ptr;
  logic [NUM_REQ-1:0]    pick;
  logic [OW-1:0]         pick_idx;
  logic                  any;
  logic                  arb_point;
  logic                  do_grant;
  logic                  do_revert;
  logic [LCD_LINE_W-1:0] sel_line1;
  logic [LCD_LINE_W-1:0] sel_line2;

`ifdef LCD_SCHED_RR_EN
  localparam bit RR_EN = 1'b1;

  // Pointer remembers the last winner; reset value makes requester 0 win first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= OW'(NUM_REQ - 1);
    end else if (do_grant) begin
      ptr <= pick_idx;
    end
  end
`else
  localparam bit RR_EN = 1'b0;

  assign ptr = OW'(NUM_REQ - 1);
`endif

  lcd_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .RR_EN   (RR_EN)
  ) u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  // Requests only count in IDLE or once the dwell of the shown message has run out.
  always_comb begin
    arb_point = (state == IDLE) || (cnt == '0);
    do_grant  = arb_point && any;
    do_revert = (state == SHOW) && (cnt == '0) && !any;
  end

  // Mux the winner's lines; pick is one-hot so an OR of gated slices suffices.
  always_comb begin
    sel_line1 = '0;
    sel_line2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_line1 = sel_line1 | req_line1[i*LCD_LINE_W +: LCD_LINE_W];
        sel_line2 = sel_line2 | req_line2[i*LCD_LINE_W +: LCD_LINE_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: enter SHOW on any grant, drop back to IDLE when dwell ends unclaimed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (do_grant)  state_nxt = SHOW;
      SHOW:    if (do_revert) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    busy = (state == SHOW);
  end

  // Display registers, pulses and dwell counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line1       <= DEFAULT_LINE1;
      line2       <= DEFAULT_LINE2;
      grant       <= '0;
      upd         <= 1'b0;
      owner       <= '0;
      owner_valid <= 1'b0;
      cnt         <= '0;
    end else begin
      grant <= '0;
      upd   <= 1'b0;
      if (do_grant) begin
        line1       <= sel_line1;
        line2       <= sel_line2;
        grant       <= pick;
        upd         <= 1'b1;
        owner       <= pick_idx;
        owner_valid <= 1'b1;
        cnt         <= CNT_LOAD;
      end else if (do_revert) begin
        line1       <= DEFAULT_LINE1;
        line2       <= DEFAULT_LINE2;
        upd         <= 1'b1;
        owner_valid <= 1'b0;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// tb/tb_lcd_msg_scheduler.sv - scoreboard bench for lcd_msg_scheduler (NUM_REQ=2, DWELL_CYCLES=8)
module tb_lcd_msg_scheduler;

  localparam int N = 2;
  localparam int D = 8;

  localparam logic [127:0] BL = {16{8'h20}};
  localparam logic [127:0] U1 = "I am User";
  localparam logic [127:0] U2 = "status ok";
  localparam logic [127:0] A1 = "Admin line one";
  localparam logic [127:0] A2 = "Admin line two";
  localparam logic [127:0] B1 = "User line one";
  localparam logic [127:0] B2 = "User line two";
  localparam logic [127:0] V1 = "late req0";
  localparam logic [127:0] V2 = "late req0 l2";
  localparam logic [127:0] W1 = "to be reset";
  localparam logic [127:0] W2 = "to be reset 2";
  localparam logic [127:0] X1 = "after reset";
  localparam logic [127:0] X2 = "after reset 2";
  localparam logic [127:0] Y1 = "served";
  localparam logic [127:0] Y2 = "served 2";
  localparam logic [127:0] Z1 = "withdrawn";
  localparam logic [127:0] Z2 = "withdrawn 2";

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*128-1:0] req_line1;
  logic [N*128-1:0] req_line2;
  logic [N-1:0]   grant;
  logic [127:0]   line1;
  logic [127:0]   line2;
  logic           upd;
  logic           owner;
  logic           owner_valid;
  logic           busy;

  lcd_msg_scheduler #(
    .NUM_REQ      (N),
    .DWELL_CYCLES (D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_line1   (req_line1),
    .req_line2   (req_line2),
    .grant       (grant),
    .line1       (line1),
    .line2       (line2),
    .upd         (upd),
    .owner       (owner),
    .owner_valid (owner_valid),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           c;
    logic [1:0]   g;
    logic [127:0] l1;
    logic [127:0] l2;
    logic         o;
    logic         ov;
    bit           chk_o;
  } ev_t;

  ev_t sbq[$];
  ev_t e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_ev(input int c, input logic [1:0] g, input logic [127:0] l1,
                        input logic [127:0] l2, input logic o, input logic ov, input bit co);
    ev_t x;
    x.c = c; x.g = g; x.l1 = l1; x.l2 = l2; x.o = o; x.ov = ov; x.chk_o = co;
    sbq.push_back(x);
  endtask

  // Monitor: every grant/upd the DUT presents must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (grant != '0 || upd)) begin
      chk("grant_onehot", 128'($countones(grant) <= 1), 128'(1));
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got grant=%b upd=%b at cycle %0d, required no output", grant, upd, cyc);
      end else begin
        e = sbq.pop_front();
        chk("ev_cycle", 128'(cyc), 128'(e.c));
        chk("ev_grant", 128'(grant), 128'(e.g));
        chk("ev_upd", 128'(upd), 128'(1));
        chk("ev_line1", line1, e.l1);
        chk("ev_line2", line2, e.l2);
        chk("ev_owner_valid", 128'(owner_valid), 128'(e.ov));
        if (e.chk_o) chk("ev_owner", 128'(owner), 128'(e.o));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int c;

  initial begin
    rst = 1'b1;
    req = '0;
    req_line1 = '0;
    req_line2 = '0;
    tick(2);
    rst = 1'b0;

    // reset / idle state
    chk("rst_line1", line1, BL);
    chk("rst_line2", line2, BL);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_upd", 128'(upd), 128'(0));
    chk("rst_owner", 128'(owner), 128'(0));
    chk("rst_owner_valid", 128'(owner_valid), 128'(0));
    tick(2);
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_line1", line1, BL);

    // single request from requester 1, then revert
    c = cyc;
    req_line1[255:128] = U1;
    req_line2[255:128] = U2;
    req = 2'b10;
    exp_ev(c + 1, 2'b10, U1, U2, 1'b1, 1'b1, 1'b1);
    exp_ev(c + 1 + D, 2'b00, BL, BL, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("s1_busy_start", 128'(busy), 128'(1));
    req = 2'b00;
    tick(D - 1);
    chk("s1_busy_end", 128'(busy), 128'(1));
    tick(1);
    chk("s1_busy_after", 128'(busy), 128'(0));
    chk("s1_owner_valid_after", 128'(owner_valid), 128'(0));
    tick(2);

    // both requesters held from IDLE: back-to-back grants
    c = cyc;
    req_line1[127:0] = A1;   req_line2[127:0] = A2;
    req_line1[255:128] = B1; req_line2[255:128] = B2;
    req = 2'b11;
    exp_ev(c + 1, 2'b01, A1, A2, 1'b0, 1'b1, 1'b1);
`ifdef LCD_SCHED_RR_EN
    exp_ev(c + 1 + D, 2'b10, B1, B2, 1'b1, 1'b1, 1'b1);
`else
    exp_ev(c + 1 + D, 2'b01, A1, A2, 1'b0, 1'b1, 1'b1);
`endif
    exp_ev(c + 1 + 2*D, 2'b00, BL, BL, 1'b0, 1'b0, 1'b0);
    for (int j = 1; j <= 2*D; j++) begin
      tick(1);
      chk("s2_busy_contig", 128'(busy), 128'(1));
      if (j == D + 1) req = 2'b00;
    end
    tick(1);
    chk("s2_busy_after", 128'(busy), 128'(0));
    tick(2);

    // req[0] raised mid-dwell (counter==5) during requester 1's message
    c = cyc;
    req_line1[255:128] = U1; req_line2[255:128] = U2;
    req = 2'b10;
    exp_ev(c + 1, 2'b10, U1, U2, 1'b1, 1'b1, 1'b1);
    exp_ev(c + 1 + D, 2'b01, V1, V2, 1'b0, 1'b1, 1'b1);
    exp_ev(c + 1 + 2*D, 2'b00, BL, BL, 1'b0, 1'b0, 1'b0);
    tick(1);
    req = 2'b00;
    tick(2);
    req_line1[127:0] = V1; req_line2[127:0] = V2;
    req = 2'b01;
    tick(D - 3);
    chk("s3_busy_pre", 128'(busy), 128'(1));
    tick(1);
    chk("s3_busy_no_idle", 128'(busy), 128'(1));
    chk("s3_owner_valid", 128'(owner_valid), 128'(1));
    req = 2'b00;
    tick(D);
    chk("s3_busy_after", 128'(busy), 128'(0));
    tick(2);

    // asynchronous reset at counter==3
    c = cyc;
    req_line1[127:0] = W1; req_line2[127:0] = W2;
    req = 2'b01;
    exp_ev(c + 1, 2'b01, W1, W2, 1'b0, 1'b1, 1'b1);
    tick(1);
    req = 2'b00;
    tick(4);
    #2 rst = 1'b1;
    #1;
    chk("ar_line1", line1, BL);
    chk("ar_line2", line2, BL);
    chk("ar_busy", 128'(busy), 128'(0));
    chk("ar_grant", 128'(grant), 128'(0));
    chk("ar_upd", 128'(upd), 128'(0));
    chk("ar_owner", 128'(owner), 128'(0));
    chk("ar_owner_valid", 128'(owner_valid), 128'(0));
    #1 rst = 1'b0;
    tick(2);
    chk("ar_idle_busy", 128'(busy), 128'(0));
    c = cyc;
    req_line1[255:128] = X1; req_line2[255:128] = X2;
    req = 2'b10;
    exp_ev(c + 1, 2'b10, X1, X2, 1'b1, 1'b1, 1'b1);
    exp_ev(c + 1 + D, 2'b00, BL, BL, 1'b0, 1'b0, 1'b0);
    tick(1);
    req = 2'b00;
    tick(D);
    chk("ar_after_busy", 128'(busy), 128'(0));
    tick(2);

    // req[1] withdrawn before grant while req[0] is shown
    c = cyc;
    req_line1[127:0] = Y1; req_line2[127:0] = Y2;
    req = 2'b01;
    exp_ev(c + 1, 2'b01, Y1, Y2, 1'b0, 1'b1, 1'b1);
    exp_ev(c + 1 + D, 2'b00, BL, BL, 1'b0, 1'b0, 1'b0);
    tick(1);
    req_line1[255:128] = Z1; req_line2[255:128] = Z2;
    req = 2'b10;
    tick(3);
    req = 2'b00;
    tick(D - 3);
    chk("wd_busy_after", 128'(busy), 128'(0));
    chk("wd_line1", line1, BL);

    for (int k = 0; k < 20 && sbq.size() != 0; k++) tick(1);
    tick(4);
    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_msg_scheduler.md
# lcd_msg_scheduler

Shares the two-line character LCD (`LCD_display`) between several message requesters, such as user and admin status sources. Each requester posts a 128-bit line1/line2 pair and waits for a one-cycle grant. The scheduler latches the granted message, holds it on the display for a minimum dwell time, and arbitrates among pending requests. When no request is pending it reverts to a default message. It sits directly upstream of `LCD_display` and drives its `line1`/`line2` inputs.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; must be ≥ 2.
- `DWELL_CYCLES`, 50_000_000: minimum cycles each granted message is shown; must be ≥ 1.
- `DEFAULT_LINE1`, 128'h2020…20 (16 ASCII spaces): idle line 1.
- `DEFAULT_LINE2`, 128'h2020…20: idle line 2.

Ports:
- `clk`, in, 1: system clock. One clock domain; all logic is on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req`, in, NUM_REQ: per-requester request; held high with stable data until grant.
- `req_line1`, in, NUM_REQ*128: flattened line1 data; requester i uses bits [i*128 +: 128].
- `req_line2`, in, NUM_REQ*128: flattened line2 data, packed the same way.
- `grant`, out, NUM_REQ: one-hot, one-cycle pulse marking the accepted requester.
- `line1`, out, 128: registered line 1 to `LCD_display`.
- `line2`, out, 128: registered line 2 to `LCD_display`.
- `upd`, out, 1: one-cycle pulse whenever `line1`/`line2` change value source (grant or revert).
- `owner`, out, $clog2(NUM_REQ): index of the current message owner.
- `owner_valid`, out, 1: high while a requester's message is displayed.
- `busy`, out, 1: high in SHOW.

## Operation
- Reset values:
  - state = IDLE
  - `line1`/`line2` = the DEFAULT values
  - `grant` = 0, `upd` = 0, `owner` = 0, `owner_valid` = 0, `busy` = 0
  - dwell counter = 0
  - round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- IDLE:
  - If `|req` is high at a clock edge, pick a winner. On that same edge: latch the winner's lines, set `grant[w]`=1, `upd`=1, `owner`=w, `owner_valid`=1, load counter = DWELL_CYCLES-1, and go to SHOW.
- SHOW:
  - `req` is ignored while the counter is nonzero; the counter decrements each cycle.
  - At counter==0 with `|req` high: re-arbitrate and grant as in IDLE, staying in SHOW. This is back-to-back with no idle cycle. The same owner may be regranted.
  - At counter==0 with no request: go to IDLE, load the DEFAULT lines, pulse `upd`, and clear `owner_valid`.
- Winner selection:
  - Round-robin: the first set `req` bit searching upward from pointer+1, wrapping modulo NUM_REQ. The pointer is updated to the winner on every grant.
- Requester rules:
  - Deassert `req` in the cycle `grant` is seen. If `req` stays high, it is a new request, served at the next arbitration point.
  - Dropping `req` before grant withdraws the request. Data is only sampled on the granting edge.
- Asserting `rst` mid-SHOW aborts immediately to the reset values. No `upd` pulse is generated.

## Timing
- Latency: `req` sampled high at edge k in IDLE gives `grant`/`upd`/new lines/`busy` visible after edge k. A request is therefore served one cycle after it is presented.
- A granted message is displayed for exactly DWELL_CYCLES cycles before the next arbitration edge.
- `grant` and `upd` are always single-cycle pulses, and at most one `grant` bit is set at a time.
- `busy` is high for DWELL_CYCLES cycles per grant, contiguous across back-to-back grants.

## Configuration
- `LCD_SCHED_RR_EN`:
  - Defined: round-robin selection as above.
  - Undefined: fixed priority, lowest index wins. The pointer logic is not built, and requester 0 can starve the others.

## Structure
- Shared package `lcd_pkg`:
  - `LCD_LINE_W` = 128
  - `LCD_BLANK_LINE` (16 × 8'h20)
  - state enum {IDLE, SHOW}
- Sub-module `lcd_rr_pick`: combinational one-hot winner from `req`, the pointer and the mode. It is reusable by other shared-resource arbiters.

## Test plan
Bench settings: NUM_REQ=2, DWELL_CYCLES=8, default lines.
- Reset, then idle → `line1`=`line2`=128'h2020…20, `busy`=0, `grant`=0, `upd`=0, `owner_valid`=0.
- `req`=2'b10 with `req_line1`[255:128]="I am User" → next cycle `grant`=2'b10, `upd`=1, `owner`=1, `line1`="I am User". After 8 cycles the lines revert to blank with an `upd` pulse and `owner_valid`=0.
- `req`=2'b11 held from IDLE → `grant`=01, then exactly 8 cycles later `grant`=10 with `busy` staying high. Without `LCD_SCHED_RR_EN`, the second grant is 01 again.
- `req[0]` raised at dwell counter==5 during requester 1's message → no grant until the dwell ends, then `grant`=01 with no IDLE cycle between messages.
- `rst` pulsed asynchronously mid-SHOW (counter==3) → outputs return to reset values before the next clock edge. The next request is granted normally.
- `req[1]` dropped before grant while `req[0]` is being served → requester 1 is never granted, and the lines revert after requester 0's dwell.
